// File: rtl/fifo_stream_pkg.sv
// Shared defaults and width helpers for the FIFO read-side stream stage.
// Imported by the skid buffer and the top-level drain logic.
package fifo_stream_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int SKID_DEPTH_DEF = 3;
  localparam int CNT_WIDTH_DEF  = 16;

  // Occupancy must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointers only index 0..depth-1; keep at least one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int OCC_W_DEF = occ_width(SKID_DEPTH_DEF);

  typedef logic [OCC_W_DEF-1:0] occ_t;

endpackage

// File: rtl/skid_buf.sv
// Circular skid storage that absorbs the FIFO read latency.
// Push writes at wr_ptr, pop retires rd_ptr; head word reads as zero when empty.
module skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = SKID_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [DATA_WIDTH-1:0]          push_data,
  input  logic                           pop,
  output logic [occ_width(DEPTH)-1:0]    occ,
  output logic [DATA_WIDTH-1:0]          head_data
);

  localparam int OCC_W = occ_width(DEPTH);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occ_reg;

  // Each entry is its own register so the whole buffer clears on reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem[gi] <= '0;
        end else if (push && (wr_ptr == PTR_W'(gi))) begin
          mem[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg <= '0;
    end else begin
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign occ       = occ_reg;
  assign head_data = (occ_reg == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a synchronous FIFO into a valid/ready stream without ever reading it empty.
// Reads are issued from registered state only, so m_ready never reaches fifo_rd_en.
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SKID_DEPTH = SKID_DEPTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic                  err_underflow
);

  localparam int OCC_W = occ_width(SKID_DEPTH);

  logic             inflight;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   pending;
  logic             room;
  logic             pop;

  // Words already buffered plus the one still in the FIFO output register.
  assign pending = {1'b0, occ} + (OCC_W + 1)'(inflight);
  assign room    = pending < (OCC_W + 1)'(SKID_DEPTH);

  assign fifo_rd_en = rst_n && !fifo_empty && room;
  assign m_valid    = (occ != '0);
  assign pop        = m_valid && m_ready;

  skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  // Diagnostic only: a FIFO underflow never alters the stream path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (fifo_underflow) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side drain stage that sits directly downstream of the synchronous FIFO. It issues FIFO read requests, absorbs the FIFO's one-cycle read latency in a small skid buffer, and presents words on a valid/ready stream. It never reads an empty FIFO, preserves order, counts accepted transfers and latches any FIFO underflow as a sticky error.

Parameters:
DATA_WIDTH, 16, width of FIFO data and stream data.
SKID_DEPTH, 3, skid buffer entries. Minimum 3 gives full throughput without a combinational m_ready-to-fifo_rd_en path.
CNT_WIDTH, 16, width of the transfer counter.

Ports:
clk  in  1  single clock, all state on posedge.
rst_n  in  1  asynchronous active-low reset, shared with the FIFO.
fifo_empty  in  1  FIFO empty flag.
fifo_data_out  in  DATA_WIDTH  FIFO registered read data, valid the cycle after a read.
fifo_underflow  in  1  FIFO underflow flag.
fifo_rd_en  out  1  read request to FIFO.
m_valid  out  1  stream word available.
m_data  out  DATA_WIDTH  stream word.
m_ready  in  1  downstream accepts.
xfer_cnt  out  CNT_WIDTH  accepted-word count.
err_underflow  out  1  sticky underflow error.

Behaviour:
- Reset (async assert, sync release): occupancy occ=0, inflight=0, wr_ptr=rd_ptr=0, buffer cleared, xfer_cnt=0, err_underflow=0. Outputs during reset: fifo_rd_en=0 (gated by rst_n), m_valid=0, m_data=0.
- Read issue: fifo_rd_en = rst_n && !fifo_empty && (occ + inflight) < SKID_DEPTH. The issue logic uses only registered state and fifo_empty. m_ready must not reach fifo_rd_en combinationally.
- inflight register: inflight <= fifo_rd_en each cycle.
- Capture: if inflight, write fifo_data_out to buf[wr_ptr] and advance wr_ptr modulo SKID_DEPTH.
- Pop: pop = m_valid && m_ready. On pop, advance rd_ptr modulo SKID_DEPTH and increment xfer_cnt, which wraps at 2^CNT_WIDTH.
- Simultaneous events: capture and pop in the same cycle leave occ unchanged. Otherwise occ +1 on capture only, -1 on pop only.
- Output: m_valid = (occ != 0). m_data = buf[rd_ptr], or 0 when occ=0.
- Stability: while m_valid && !m_ready, m_data is held stable.
- Overflow guard: occ + inflight never exceeds SKID_DEPTH, so a capture always has space.
- Latency: fifo_empty falls in cycle N, fifo_rd_en is high in N, data is valid from the FIFO in N+1, and m_valid rises in N+2.
- Throughput: 1 word/cycle when m_ready is held high and the FIFO is non-empty.
- Empty boundary: with one word in the FIFO, the block issues exactly one read. fifo_rd_en stays low from the cycle fifo_empty is high.
- Wrap-around: pointers wrap at SKID_DEPTH; order is preserved across the wrap.
- err_underflow is set when fifo_underflow is sampled high and cleared only by reset. It is a diagnostic; the stream itself is unaffected.
- Reset mid-operation: buffered and in-flight words are discarded. There is no stale m_valid after release.

Decomposition:
- Shared package fifo_stream_pkg holds the DATA_WIDTH default, the SKID_DEPTH default, and a typedef for the occupancy/pointer width (clog2(SKID_DEPTH+1)).
- One natural sub-module: skid_buf. It contains the circular storage, pointers and occupancy (push, pop, occ, head data).
- The top module holds the read-issue logic, inflight register, counter and error flag.

Test Plan:
1. Reset behaviour: rst_n low with the FIFO holding 4 words. Required: fifo_rd_en=0, m_valid=0, m_data=0, xfer_cnt=0, err_underflow=0 immediately on assert, without waiting for a clock edge.
2. Streaming: write 0x0001..0x0008 with m_ready=1. Required: m_valid rises 2 cycles after fifo_empty falls; m_data is 1..8 on consecutive cycles; xfer_cnt=8; fifo_underflow never asserts.
3. Backpressure: FIFO holds 5 words and m_ready=0. Required: exactly 3 fifo_rd_en pulses, m_data=first word held, FIFO left with 2 words. Then raise m_ready: all 5 words emerge in order and xfer_cnt=5.
4. Toggling ready: stream 12 words with m_ready toggling 1,0,1,0. Required: m_data unchanged while m_valid && !m_ready; order is preserved across pointer wrap; xfer_cnt=12.
5. Single word and forced error: one word in the FIFO. Required: one fifo_rd_en pulse, none while fifo_empty=1. Then force a 1-cycle fifo_underflow pulse: err_underflow=1 and stays 1 until rst_n is asserted.
6. Reset mid-stream: pulse rst_n low for 1 cycle with occ=2 and inflight=1. Required: outputs clear asynchronously; after release m_valid=0 until new FIFO writes arrive; no stale words appear.
